// File: rtl/multdiv_unit_if.sv
// Operand/result bundle between the processor pipeline and the iterative multiply/divide unit.
interface multdiv_unit_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (Booth radix-2) and restoring divide, 33-edge latency,
// single-cycle result-ready pulse; a new start pulse aborts and restarts any operation.
module multdiv_unit (
  input  logic           clock,
  input  logic           reset,
  multdiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [65:0] prod_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [31:0] result_r;
  logic        exc_r;
  logic        rdy_r;
  logic        busy_r;

  logic [32:0] acc_s;
  logic [65:0] prod_next_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] div_q_s;
  logic        div_exc_s;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic fits_s32(input logic [63:0] p);
    fits_s32 = (&p[63:31]) | ~(|p[63:31]);
  endfunction

  // Booth step: 33-bit accumulator absorbs +/- 0x80000000 without overflow, then arithmetic shift.
  always_comb begin
    acc_s = prod_r[65:33];
    case (prod_r[1:0])
      2'b01:   acc_s = prod_r[65:33] + {op_a_r[31], op_a_r};
      2'b10:   acc_s = prod_r[65:33] - {op_a_r[31], op_a_r};
      default: acc_s = prod_r[65:33];
    endcase
    prod_next_s = {acc_s[32], acc_s, prod_r[32:1]};
  end

  // Restoring divide step on magnitudes, plus final sign correction and special cases.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[31]};
    diff_s   = rem_sh_s - {1'b0, dvs_r};
    if (!diff_s[32]) begin
      rem_next_s = diff_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = rem_sh_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end
    if (op_b_r == 32'd0) begin
      div_q_s   = 32'd0;
      div_exc_s = 1'b1;
    end else if ((op_a_r == 32'h8000_0000) && (op_b_r == 32'hFFFF_FFFF)) begin
      div_q_s   = 32'h8000_0000;
      div_exc_s = 1'b1;
    end else begin
      div_q_s   = (op_a_r[31] ^ op_b_r[31]) ? (32'd0 - quo_r) : quo_r;
      div_exc_s = 1'b0;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      op_a_r   <= 32'd0;
      op_b_r   <= 32'd0;
      prod_r   <= 66'd0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      dvs_r    <= 32'd0;
      result_r <= 32'd0;
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      state_r <= bus.ctrl_MULT ? MUL : DIV;
      cnt_r   <= 6'd0;
      op_a_r  <= bus.data_operandA;
      op_b_r  <= bus.data_operandB;
      prod_r  <= {33'd0, bus.data_operandB, 1'b0};
      rem_r   <= 32'd0;
      quo_r   <= mag32(bus.data_operandA);
      dvs_r   <= mag32(bus.data_operandB);
      rdy_r   <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          rdy_r  <= 1'b0;
          busy_r <= 1'b0;
        end
        MUL: begin
          if (cnt_r == 6'd32) begin
            state_r  <= DONE;
            result_r <= prod_r[32:1];
            exc_r    <= ~fits_s32(prod_r[64:1]);
            rdy_r    <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            prod_r <= prod_next_s;
            cnt_r  <= cnt_r + 6'd1;
          end
        end
        DIV: begin
          if (cnt_r == 6'd32) begin
            state_r  <= DONE;
            result_r <= div_q_s;
            exc_r    <= div_exc_s;
            rdy_r    <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_exception = exc_r;
  assign bus.data_resultRDY = rdy_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, abort/reset sequences, random ops vs model.
module tb_multdiv_unit;

  logic clock;
  logic reset;
  multdiv_unit_if bus ();

  multdiv_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_res;
  logic        last_exc;

  typedef struct {
    bit        mul;
    bit        div;
    bit [31:0] a;
    bit [31:0] b;
    bit [31:0] exp_res;
    bit        exp_exc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic with the two divide special cases.
  task automatic model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint p;
    longint q;
    if (mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      q   = longint'($signed(a)) / longint'($signed(b));
      res = q[31:0];
      exc = 1'b0;
    end
  endtask

  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for the ready pulse, checking latency, busy, output hold and single pulse.
  task automatic wait_result(input string name, input logic [31:0] exp_res, input logic exp_exc);
    int          lat;
    bit          busy_ok;
    bit          hold_ok;
    logic [31:0] res;
    logic        exc;
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1; res = 32'hx; exc = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      idle_cycle();
      if (bus.data_resultRDY === 1'b1) begin
        lat = k;
        res = bus.data_result;
        exc = bus.data_exception;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.data_result !== last_res || bus.data_exception !== last_exc) hold_ok = 1'b0;
    end
    chk({name, " latency"}, lat, 32'd33);
    chk({name, " result"}, res, exp_res);
    chk({name, " exception"}, {31'd0, exc}, {31'd0, exp_exc});
    chk({name, " busy during op"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " outputs held"}, {31'd0, hold_ok}, 32'd1);
    idle_cycle();
    chk({name, " rdy single pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
    chk({name, " busy after done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " result kept"}, bus.data_result, exp_res);
    last_res = exp_res;
    last_exc = exp_exc;
  endtask

  vec_t vecs [13];

  initial begin
    logic [31:0] er;
    logic        ee;
    bit          no_rdy;
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'd6,          32'd3,         32'd18,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'd100,        32'd7,         32'd14,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FF9C, 32'd0,         1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0};

    // Reset with a simultaneous start pulse: reset must win.
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'd0; bus.data_operandB = 32'd0;
    @(negedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd3;
    @(posedge clock); #1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    chk("reset result", bus.data_result, 32'd0);
    chk("reset exception", {31'd0, bus.data_exception}, 32'd0);
    last_res = 32'd0;
    last_exc = 1'b0;

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_exc);
    end

    // DIV aborted by a MULT ten cycles in: only the MULT may report.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    no_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      idle_cycle();
      if (bus.data_resultRDY !== 1'b0) no_rdy = 1'b0;
    end
    chk("abort no early rdy", {31'd0, no_rdy}, 32'd1);
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    wait_result("abort mult", 32'd12, 1'b0);

    // Reset at iteration 20 of a MULT discards it.
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    for (int k = 0; k < 20; k++) idle_cycle();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b1;
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset result", bus.data_result, 32'd0);
    chk("midreset exception", {31'd0, bus.data_exception}, 32'd0);
    no_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      idle_cycle();
      if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) no_rdy = 1'b0;
    end
    chk("midreset no rdy", {31'd0, no_rdy}, 32'd1);
    last_res = 32'd0;
    last_exc = 1'b0;

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       begin m = 1'b1; d = 1'b0; end
        1:       begin m = 1'b0; d = 1'b1; end
        default: begin m = 1'b1; d = 1'b1; end
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 31);
      if ($urandom_range(0, 3) == 0) b = $signed(b) >>> $urandom_range(8, 31);
      if ($urandom_range(0, 15) == 0) b = 32'd0;
      model(m, a, b, er, ee);
      start_op(m, d, a, b);
      wait_result($sformatf("rand%0d", i), er, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
